// File: rtl/ssp_frame_ctrl.sv
// ssp_frame_ctrl: master-mode SSP frame sequencer between the TX FIFO, the RX FIFO and the SSP pins
module ssp_frame_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              enable,
  input  logic [DATA_W-1:0] TxData,
  input  logic              tx_empty,
  output logic              tx_pop,
  input  logic              rx_full,
  output logic [DATA_W-1:0] RxData,
  output logic              rx_ready,
  output logic              SSPCLKOUT,
  output logic              SSPFSSOUT,
  output logic              SSPTXD,
  output logic              SSPOE_B,
  input  logic              SSPRXD,
  output logic              busy
);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, PUSH} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic ph_q, ph_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
  logic rdy_q, rdy_d;
  logic run, htick, start;
  assign run = state_q == SYNC || state_q == SHIFT;
  assign htick = run && hcnt_q == HMAX;
  assign start = enable && !tx_empty;
  assign SSPCLKOUT = run && ph_q;
  assign SSPFSSOUT = state_q == SYNC;
  assign SSPTXD = state_q == SHIFT && tx_q[DATA_W-1];
  assign SSPOE_B = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign RxData = rxd_q;
  assign rx_ready = rdy_q;
  // next state: divider/phase advance while framing, FIFO handshakes in IDLE and PUSH
  always_comb begin
    state_d = state_q;
    hcnt_d = run ? (htick ? '0 : hcnt_q + 1'b1) : '0;
    ph_d = run ? ph_q ^ htick : 1'b0;
    bit_d = bit_q;
    tx_d = tx_q;
    rx_d = rx_q;
    rxd_d = rxd_q;
    rdy_d = 1'b0;
    tx_pop = 1'b0;
    case (state_q)
      IDLE: if (start && !rx_full) begin
        tx_pop = 1'b1;
        tx_d = TxData;
        state_d = SYNC;
      end
      SYNC: if (htick && ph_q) begin
        state_d = SHIFT;
        bit_d = BW'(DATA_W - 1);
      end
      SHIFT: if (htick) begin
        if (!ph_q) rx_d = {rx_q[DATA_W-2:0], SSPRXD};
        else begin
          tx_d = tx_q << 1;
          if (bit_q == '0) state_d = PUSH;
          else bit_d = bit_q - 1'b1;
        end
      end
      PUSH: if (!rx_full) begin
        rdy_d = 1'b1;
        rxd_d = rx_q;
        tx_pop = start;
        tx_d = start ? TxData : tx_q;
        state_d = start ? SYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any partial frame
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q <= IDLE;
      hcnt_q <= '0;
      ph_q <= 1'b0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rxd_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rxd_q <= rxd_d;
      rdy_q <= rdy_d;
    end
  end
endmodule
